dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter that shares the single-port data memory (10-bit word address, 32-bit data, one-cycle synchronous read) between the CPU MEM stage and a debug/loader port. The block sits between the pipeline's MEM stage and the data memory instance in the top level. It drives the memory's write enable, address and write data, and routes read data back with a tagged valid. When the CPU loses arbitration, the block raises a stall request that the pipeline's hazard unit ORs into its existing stall.

## Interface
- STARVE_LIMIT, 8: consecutive cycles the debug port may wait while the CPU is granted before it is forced a slot; legal range 1..255
- ADDR_W, 10: memory word-address width
- DATA_W, 32: data width
- clk  in  1  single clock; memory and all state on rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU MEM stage requests an access this cycle
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  word address
- cpu_wdata  in  DATA_W  write data
- cpu_gnt  out  1  access accepted this cycle (combinational)
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- cpu_rvalid  out  1  read data for the CPU is valid this cycle
- cpu_rdata  out  DATA_W  read data, meaningful only with cpu_rvalid
- dbg_req / dbg_we / dbg_addr / dbg_wdata / dbg_gnt / dbg_rvalid / dbg_rdata: same meanings for the debug port
- mem_we  out  1  to memory write enable
- mem_addr  out  ADDR_W  to memory address
- mem_din  out  DATA_W  to memory write data
- mem_dout  in  DATA_W  from memory, valid one cycle after a read address is presented

## Operation
- Each cycle grants at most one requester. The granted requester's we, addr and wdata are muxed onto mem_*.
- When no requester is granted: mem_we = 0, mem_addr = 0, mem_din = 0.
- Default priority is CPU.
- The debug port wins when dbg_req is asserted and either cpu_req = 0 or starve_cnt == STARVE_LIMIT.
- starve_cnt (8 bit):
  - increments when dbg_req & cpu_gnt;
  - clears to 0 on dbg_gnt or when dbg_req = 0;
  - saturates at STARVE_LIMIT.
- Requesters hold req/we/addr/wdata stable until granted. The arbiter does not latch requests.
- Read tag register (rd_pend, rd_owner) captures the granted read (~we) each cycle.
- Next cycle, rd_owner's rvalid = rd_pend and its rdata = mem_dout. The other port's rvalid = 0 and its rdata = 0.
- Writes produce no rvalid.
- Ordering is grant order. A write granted in cycle N is visible to a read granted in cycle N+1 from either port.

## Timing
- Grant is combinational from req and the registered starve_cnt. There is no comb path from mem_dout to any gnt.
- Read latency is exactly 1 cycle, grant edge to rvalid. Back-to-back reads sustain one per cycle.
- Reset values: starve_cnt = 0, rd_pend = 0, rd_owner = CPU. All rvalid = 0 and all rdata = 0.
- While rst = 1, both gnt = 0, mem_we = 0, and cpu_stall = cpu_req.
- Reset mid-read: a read granted in the reset cycle or the cycle before reset never produces rvalid.
- Simultaneous cpu_req and dbg_req with starve_cnt < STARVE_LIMIT: CPU granted.
- Simultaneous cpu_req and dbg_req with starve_cnt == STARVE_LIMIT: debug granted, cpu_stall = 1 for exactly that cycle, counter cleared.
- STARVE_LIMIT = 1: debug is granted every second cycle under continuous contention.

## Structure
- Package dmem_arb_pkg: ADDR_W and DATA_W defaults, and the requester-id enum (OWNER_CPU = 0, OWNER_DBG = 1).
- One sub-module, dmem_arb_starve: the saturating wait counter plus the force-grant compare.
- Grant mux and read-tag logic stay in the top body.

## Test plan
- Idle and reset: reset held 3 cycles with cpu_req = 1. Expect cpu_gnt = 0, cpu_stall = 1, mem_we = 0. After release, cpu_gnt = 1 in the first cycle.
- CPU write then read: CPU writes 0xDEADBEEF to addr 0x004, then reads addr 0x004. Expect cpu_rvalid = 1 and cpu_rdata = 0xDEADBEEF one cycle after the read grant, with dbg_rvalid = 0.
- Debug-only path: CPU idle, debug reads addr 0x3FF (preloaded 0x12345678). Expect dbg_gnt immediately and dbg_rvalid with 0x12345678 the next cycle.
- Starvation, STARVE_LIMIT = 8: cpu_req and dbg_req held constantly. Expect 8 CPU grants, then 1 debug grant with cpu_stall = 1 for that cycle, repeating with period 9.
- Cross-port ordering: debug writes 0x0000AAAA to addr 0x010 in cycle N, CPU reads addr 0x010 in cycle N+1. Expect cpu_rdata = 0x0000AAAA.
- Reset mid-read: CPU read granted in the cycle rst rises. Expect no cpu_rvalid in any cycle that follows.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and width defaults for the data-memory arbiter slice.
// Requester ids tag which port owns an in-flight read.
package dmem_arb_pkg;

  localparam int DMEM_ADDR_W = 10;
  localparam int DMEM_DATA_W = 32;
  localparam int STARVE_CNT_W = 8;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DBG = 1'b1
  } owner_e;

  // True when the granted access is a read that will need a tagged response.
  function automatic logic is_read_grant(input logic gnt, input logic we);
    return gnt & ~we;
  endfunction

endpackage

// File: rtl/dmem_arb_starve.sv
// Saturating wait counter for the debug port and the force-grant compare.
// The force flag is purely registered so grant has no path from memory data.
module dmem_arb_starve
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_dbg_req,
  input  logic i_cpu_gnt,
  input  logic i_dbg_gnt,
  output logic o_force_dbg
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] r_starve_cnt;
  logic                    w_at_limit;

  assign w_at_limit  = (r_starve_cnt == LIMIT);
  assign o_force_dbg = w_at_limit;

  // Count only cycles the debug port actually lost to the CPU; any debug
  // grant or a dropped request restarts the wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (!i_dbg_req || i_dbg_gnt) begin
      r_starve_cnt <= '0;
    end else if (i_cpu_gnt && !w_at_limit) begin
      r_starve_cnt <= r_starve_cnt + STARVE_CNT_W'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing the single-port data memory between the CPU MEM
// stage and the debug/loader port, with tagged one-cycle read return.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int ADDR_W       = DMEM_ADDR_W,
  parameter int DATA_W       = DMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  logic   w_force_dbg;
  logic   w_cpu_gnt;
  logic   w_dbg_gnt;
  logic   w_rd_valid;
  logic   r_rd_pend;
  owner_e r_rd_owner;

  dmem_arb_starve #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk        (clk),
    .rst        (rst),
    .i_dbg_req  (dbg_req),
    .i_cpu_gnt  (w_cpu_gnt),
    .i_dbg_gnt  (w_dbg_gnt),
    .o_force_dbg(w_force_dbg)
  );

  // CPU has priority unless the debug port has waited its full allowance.
  always_comb begin
    w_cpu_gnt = 1'b0;
    w_dbg_gnt = 1'b0;
    if (!rst) begin
      if (dbg_req && (!cpu_req || w_force_dbg)) begin
        w_dbg_gnt = 1'b1;
      end else if (cpu_req) begin
        w_cpu_gnt = 1'b1;
      end
    end
  end

  assign cpu_gnt   = w_cpu_gnt;
  assign dbg_gnt   = w_dbg_gnt;
  assign cpu_stall = cpu_req & ~w_cpu_gnt;

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (w_cpu_gnt) begin
      mem_we   = cpu_we;
      mem_addr = cpu_addr;
      mem_din  = cpu_wdata;
    end else if (w_dbg_gnt) begin
      mem_we   = dbg_we;
      mem_addr = dbg_addr;
      mem_din  = dbg_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_pend  <= 1'b0;
      r_rd_owner <= OWNER_CPU;
    end else begin
      r_rd_pend <= is_read_grant(w_cpu_gnt, cpu_we) | is_read_grant(w_dbg_gnt, dbg_we);
      if (w_dbg_gnt) begin
        r_rd_owner <= OWNER_DBG;
      end else if (w_cpu_gnt) begin
        r_rd_owner <= OWNER_CPU;
      end
    end
  end

  // A read granted just before reset is dropped rather than returned.
  assign w_rd_valid = r_rd_pend & ~rst;

  assign cpu_rvalid = w_rd_valid & (r_rd_owner == OWNER_CPU);
  assign dbg_rvalid = w_rd_valid & (r_rd_owner == OWNER_DBG);
  assign cpu_rdata  = cpu_rvalid ? mem_dout : '0;
  assign dbg_rdata  = dbg_rvalid ? mem_dout : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural one-cycle memory
// and a read-response scoreboard.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int LIMIT = 8;
  localparam int AW    = DMEM_ADDR_W;
  localparam int DW    = DMEM_DATA_W;

  typedef struct {
    owner_e        owner;
    logic [DW-1:0] data;
  } rdExp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, dbg_req, dbg_we;
  logic [AW-1:0] cpu_addr, dbg_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata;
  logic          cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [DW-1:0] cpu_rdata, dbg_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;

  logic [DW-1:0] memArray [0:(1<<AW)-1];
  rdExp_t        scoreQ[$];
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // Read-first single-port memory with one-cycle read latency.
  always @(posedge clk) begin
    mem_dout <= memArray[mem_addr];
    if (mem_we) memArray[mem_addr] = mem_din;
  end

  // Every returned read must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (cpu_rvalid || dbg_rvalid) begin
      rdExp_t e;
      checks++;
      if (cpu_rvalid && dbg_rvalid) begin
        errors++;
        $display("[TB] FAIL rvalid_both cpu_rvalid=%b dbg_rvalid=%b want one", cpu_rvalid, dbg_rvalid);
      end else if (scoreQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL rvalid_unexpected cpu_rvalid=%b dbg_rvalid=%b want none", cpu_rvalid, dbg_rvalid);
      end else begin
        e = scoreQ.pop_front();
        if (e.owner == OWNER_CPU) begin
          if (!cpu_rvalid || cpu_rdata !== e.data || dbg_rdata !== '0) begin
            errors++;
            $display("[TB] FAIL cpu_read got rvalid=%b rdata=%h dbg_rdata=%h want rvalid=1 rdata=%h dbg_rdata=0",
                     cpu_rvalid, cpu_rdata, dbg_rdata, e.data);
          end
        end else begin
          if (!dbg_rvalid || dbg_rdata !== e.data || cpu_rdata !== '0) begin
            errors++;
            $display("[TB] FAIL dbg_read got rvalid=%b rdata=%h cpu_rdata=%h want rvalid=1 rdata=%h cpu_rdata=0",
                     dbg_rvalid, dbg_rdata, cpu_rdata, e.data);
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic cReq, input logic cWe, input logic [AW-1:0] cAddr,
                               input logic [DW-1:0] cData, input logic dReq, input logic dWe,
                               input logic [AW-1:0] dAddr, input logic [DW-1:0] dData);
    cpu_req = cReq; cpu_we = cWe; cpu_addr = cAddr; cpu_wdata = cData;
    dbg_req = dReq; dbg_we = dWe; dbg_addr = dAddr; dbg_wdata = dData;
  endtask

  task automatic nextCycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (cpu_gnt !== 1'b0 || cpu_stall !== 1'b1 || mem_we !== 1'b0 || dbg_gnt !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_hold cyc=%0d got gnt=%b stall=%b mem_we=%b dbg_gnt=%b want 0 1 0 0",
                 c, cpu_gnt, cpu_stall, mem_we, dbg_gnt);
      end
      checks++;
      if (cpu_rvalid !== 1'b0 || dbg_rvalid !== 1'b0 || cpu_rdata !== '0 || dbg_rdata !== '0) begin
        errors++;
        $display("[TB] FAIL reset_outputs got crv=%b drv=%b crd=%h drd=%h want all zero",
                 cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata);
      end
      nextCycle();
    end
    rst = 1'b0;
    scoreQ.push_back('{OWNER_CPU, 32'h0});
    @(negedge clk);
    checks++;
    if (cpu_gnt !== 1'b1 || cpu_stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release got gnt=%b stall=%b want 1 0", cpu_gnt, cpu_stall);
    end
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk); #1;
    checks++;
    if (scoreQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL reset_first_read pending=%0d want 0", scoreQ.size());
    end
    nextCycle();
  endtask

  task automatic test_cpu_write_read();
    applyStimulus(1'b1, 1'b1, 10'h004, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if (cpu_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 10'h004 || mem_din !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL cpu_write got gnt=%b we=%b addr=%h din=%h want 1 1 004 deadbeef",
               cpu_gnt, mem_we, mem_addr, mem_din);
    end
    nextCycle();
    applyStimulus(1'b1, 1'b0, 10'h004, '0, 1'b0, 1'b0, '0, '0);
    scoreQ.push_back('{OWNER_CPU, 32'hDEADBEEF});
    @(negedge clk);
    checks++;
    if (cpu_gnt !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'h004) begin
      errors++;
      $display("[TB] FAIL cpu_read_issue got gnt=%b we=%b addr=%h want 1 0 004", cpu_gnt, mem_we, mem_addr);
    end
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk); #1;
    checks++;
    if (mem_we !== 1'b0 || mem_addr !== '0 || mem_din !== '0 || scoreQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL idle_after_read got we=%b addr=%h din=%h pending=%0d want 0 0 0 0",
               mem_we, mem_addr, mem_din, scoreQ.size());
    end
    nextCycle();
  endtask

  task automatic test_dbg_read();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'h3FF, '0);
    scoreQ.push_back('{OWNER_DBG, 32'h12345678});
    @(negedge clk);
    checks++;
    if (dbg_gnt !== 1'b1 || cpu_gnt !== 1'b0 || mem_addr !== 10'h3FF) begin
      errors++;
      $display("[TB] FAIL dbg_read_issue got dgnt=%b cgnt=%b addr=%h want 1 0 3ff", dbg_gnt, cpu_gnt, mem_addr);
    end
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk); #1;
    checks++;
    if (scoreQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL dbg_read_latency pending=%0d want 0", scoreQ.size());
    end
    nextCycle();
  endtask

  task automatic test_starvation();
    logic expDbg;
    applyStimulus(1'b1, 1'b0, 10'h004, '0, 1'b1, 1'b0, 10'h3FF, '0);
    for (int c = 0; c < 3 * (LIMIT + 1); c++) begin
      expDbg = ((c % (LIMIT + 1)) == LIMIT);
      if (expDbg) scoreQ.push_back('{OWNER_DBG, 32'h12345678});
      else        scoreQ.push_back('{OWNER_CPU, 32'hDEADBEEF});
      @(negedge clk);
      checks++;
      if (cpu_gnt !== ~expDbg || dbg_gnt !== expDbg || cpu_stall !== expDbg) begin
        errors++;
        $display("[TB] FAIL starve cyc=%0d got cgnt=%b dgnt=%b stall=%b want %b %b %b",
                 c, cpu_gnt, dbg_gnt, cpu_stall, ~expDbg, expDbg, expDbg);
      end
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk); #1;
    checks++;
    if (scoreQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL starve_drain pending=%0d want 0", scoreQ.size());
    end
    nextCycle();
  endtask

  task automatic test_cross_order();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 10'h010, 32'h0000AAAA);
    @(negedge clk);
    checks++;
    if (dbg_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 10'h010 || mem_din !== 32'h0000AAAA) begin
      errors++;
      $display("[TB] FAIL dbg_write got gnt=%b we=%b addr=%h din=%h want 1 1 010 0000aaaa",
               dbg_gnt, mem_we, mem_addr, mem_din);
    end
    nextCycle();
    applyStimulus(1'b1, 1'b0, 10'h010, '0, 1'b0, 1'b0, '0, '0);
    scoreQ.push_back('{OWNER_CPU, 32'h0000AAAA});
    @(negedge clk);
    checks++;
    if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL cross_read_issue got cgnt=%b dgnt=%b want 1 0", cpu_gnt, dbg_gnt);
    end
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk); #1;
    checks++;
    if (scoreQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL cross_drain pending=%0d want 0", scoreQ.size());
    end
    nextCycle();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [3];
    logic [DW-1:0] datas [3];
    addrs = '{10'h004, 10'h3FF, 10'h010};
    datas = '{32'hDEADBEEF, 32'h12345678, 32'h0000AAAA};
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, addrs[k], '0, 1'b0, 1'b0, '0, '0);
      scoreQ.push_back('{OWNER_CPU, datas[k]});
      @(negedge clk);
      checks++;
      if (cpu_gnt !== 1'b1 || mem_addr !== addrs[k]) begin
        errors++;
        $display("[TB] FAIL b2b_issue k=%0d got gnt=%b addr=%h want 1 %h", k, cpu_gnt, mem_addr, addrs[k]);
      end
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk); #1;
    checks++;
    if (scoreQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL b2b_drain pending=%0d want 0", scoreQ.size());
    end
    nextCycle();
  endtask

  task automatic test_reset_mid_read();
    applyStimulus(1'b1, 1'b0, 10'h004, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if (cpu_gnt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_read_issue got gnt=%b want 1", cpu_gnt);
    end
    nextCycle();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (cpu_rvalid !== 1'b0 || cpu_gnt !== 1'b0 || cpu_stall !== 1'b1) begin
        errors++;
        $display("[TB] FAIL mid_read_rst cyc=%0d got rvalid=%b gnt=%b stall=%b want 0 0 1",
                 c, cpu_rvalid, cpu_gnt, cpu_stall);
      end
      nextCycle();
    end
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (cpu_rvalid !== 1'b0 || dbg_rvalid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL mid_read_after cyc=%0d got crv=%b drv=%b want 0 0", c, cpu_rvalid, dbg_rvalid);
      end
      nextCycle();
    end
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) memArray[a] = '0;
    memArray[10'h3FF] = 32'h12345678;
    test_reset();
    test_cpu_write_read();
    test_dbg_read();
    test_starvation();
    test_cross_order();
    test_back_to_back();
    test_reset_mid_read();
    checks++;
    if (scoreQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL final_drain pending=%0d want 0", scoreQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
